// File: rtl/score_match_if.sv
// Bundle between the pushbutton processors (master) and the match controller (slave).
// Carries the per-player pulses and all registered scoreboard/display outputs.
interface score_match_if #(
   parameter int BW = 7
);
   logic          up_a_i;
   logic          down_a_i;
   logic          up_b_i;
   logic          down_b_i;
   logic [BW-1:0] score_a_o;
   logic [BW-1:0] score_b_o;
   logic [BW-1:0] disp_val_o;
   logic          disp_sel_o;
   logic          disp_blank_o;
   logic [1:0]    state_o;
   logic          winner_o;

   modport master (
      output up_a_i, down_a_i, up_b_i, down_b_i,
      input  score_a_o, score_b_o, disp_val_o, disp_sel_o, disp_blank_o, state_o, winner_o
   );

   modport slave (
      input  up_a_i, down_a_i, up_b_i, down_b_i,
      output score_a_o, score_b_o, disp_val_o, disp_sel_o, disp_blank_o, state_o, winner_o
   );
endinterface

// File: rtl/score_match_ctrl.sv
// Two-player match controller: scores, winner detection, display multiplexing and win blink.
// Optional macro SCORE_WIN_BY_TWO_EN selects the win-by-two / deuce rule (scores saturate at 99).
module score_match_ctrl #(
   parameter int BW        = 7,
   parameter int WIN_SCORE = 11,
   parameter int SHOW_MS   = 1000,
   parameter int BLINK_MS  = 250
) (
   input  logic         clk_1khz_i,
   input  logic         rst_i,
   score_match_if.slave bus
);

   localparam int DW = (SHOW_MS  > 1) ? $clog2(SHOW_MS)  : 1;
   localparam int KW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SHOW_MS - 1);
   localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_MS - 1);
   localparam logic [BW-1:0] WIN_L      = BW'(WIN_SCORE);
`ifdef SCORE_WIN_BY_TWO_EN
   localparam int SMAX = (((2 ** BW) - 1) < 99) ? ((2 ** BW) - 1) : 99;
`else
   localparam int SMAX = WIN_SCORE;
`endif
   localparam logic [BW-1:0] SMAX_L = BW'(SMAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_WIN  = 2'b10
   } state_t;

   state_t        r_state;
   logic [BW-1:0] r_a, r_b, r_val;
   logic          r_sel, r_blank, r_winner;
   logic [DW-1:0] r_dwell;
   logic [KW-1:0] r_blink;

   logic [BW-1:0] w_a_step, w_b_step, w_a_new, w_b_new;
   logic          w_win_a, w_win_b, w_apply, w_any_dn, w_sel_nxt;

   // Up/down on one player in the same cycle cancel; both ends saturate.
   function automatic logic [BW-1:0] f_step(input logic [BW-1:0] s, input logic up, input logic dn);
      logic [BW-1:0] v;
      v = s;
      if (up && !dn && s != SMAX_L)
         v = s + BW'(1);
      else if (dn && !up && s != '0)
         v = s - BW'(1);
      return v;
   endfunction

   always_comb begin
      w_any_dn  = bus.down_a_i | bus.down_b_i;
      w_apply   = (r_state == S_PLAY) | bus.up_a_i | bus.up_b_i;
      w_a_step  = f_step(r_a, bus.up_a_i, bus.down_a_i);
      w_b_step  = f_step(r_b, bus.up_b_i, bus.down_b_i);
      w_win_a   = 1'b0;
      w_win_b   = 1'b0;
      w_a_new   = w_a_step;
      w_b_new   = w_b_step;
`ifdef SCORE_WIN_BY_TWO_EN
      w_win_a   = (w_a_step >= WIN_L) && (w_a_step > w_b_step) && ((w_a_step - w_b_step) >= BW'(2));
      w_win_b   = (w_b_step >= WIN_L) && (w_b_step > w_a_step) && ((w_b_step - w_a_step) >= BW'(2));
`else
      w_win_a   = (w_a_step == WIN_L);
      w_win_b   = !w_win_a && (w_b_step == WIN_L);
      // A wins ties: B's increment in the deciding cycle is dropped.
      if (w_win_a && (w_b_step > r_b))
         w_b_new = r_b;
`endif
      if (!w_apply) begin
         w_a_new = r_a;
         w_b_new = r_b;
         w_win_a = 1'b0;
         w_win_b = 1'b0;
      end
      w_sel_nxt = (r_dwell == DWELL_LAST) ? ~r_sel : r_sel;
   end

   always_ff @(posedge clk_1khz_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_val    <= '0;
         r_sel    <= 1'b0;
         r_blank  <= 1'b0;
         r_winner <= 1'b0;
         r_dwell  <= '0;
         r_blink  <= '0;
      end else begin
         case (r_state)
            S_WIN: begin
               if (w_any_dn) begin
                  r_state  <= S_IDLE;
                  r_a      <= '0;
                  r_b      <= '0;
                  r_val    <= '0;
                  r_sel    <= 1'b0;
                  r_blank  <= 1'b0;
                  r_winner <= 1'b0;
                  r_dwell  <= '0;
                  r_blink  <= '0;
               end else if (r_blink == BLINK_LAST) begin
                  r_blink <= '0;
                  r_blank <= ~r_blank;
               end else begin
                  r_blink <= r_blink + KW'(1);
               end
            end
            default: begin
               r_a <= w_a_new;
               r_b <= w_b_new;
               if (w_win_a || w_win_b) begin
                  // Winner's score is shown from the entry edge; blink phase starts unblanked.
                  r_state  <= S_WIN;
                  r_winner <= w_win_b;
                  r_sel    <= w_win_b;
                  r_val    <= w_win_b ? w_b_new : w_a_new;
                  r_blink  <= '0;
                  r_blank  <= 1'b0;
                  r_dwell  <= '0;
               end else begin
                  if (w_apply)
                     r_state <= S_PLAY;
                  r_sel   <= w_sel_nxt;
                  r_val   <= w_sel_nxt ? w_b_new : w_a_new;
                  r_dwell <= (r_dwell == DWELL_LAST) ? '0 : r_dwell + DW'(1);
               end
            end
         endcase
      end
   end

   assign bus.score_a_o    = r_a;
   assign bus.score_b_o    = r_b;
   assign bus.disp_val_o   = r_val;
   assign bus.disp_sel_o   = r_sel;
   assign bus.disp_blank_o = r_blank;
   assign bus.state_o      = r_state;
   assign bus.winner_o     = r_winner;

endmodule

// File: tb/tb_score_match_ctrl.sv
// Self-checking bench for score_match_ctrl: vector table, hand sequences, random run vs rule model.
module tb_score_match_ctrl;
   localparam int BW    = 7;
   localparam int WIN   = 11;
   localparam int SHOW  = 1000;
   localparam int BLINK = 250;
`ifdef SCORE_WIN_BY_TWO_EN
   localparam int SMAX = 99;
`else
   localparam int SMAX = WIN;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   score_match_if #(.BW(BW)) bus ();

   score_match_ctrl #(.BW(BW), .WIN_SCORE(WIN), .SHOW_MS(SHOW), .BLINK_MS(BLINK)) dut (
      .clk_1khz_i (clk),
      .rst_i      (rst),
      .bus        (bus)
   );

   int checks = 0;
   int errors = 0;

   // Rule model: state 0/1/2, scores, winner, cycles spent showing scores and cycles spent in WIN.
   int m_st, m_a, m_b, m_win, m_age, m_wage;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_a = 0; m_b = 0; m_win = 0; m_age = 0; m_wage = 0;
   endtask

   function automatic int clampv(input int v);
      if (v < 0) return 0;
      if (v > SMAX) return SMAX;
      return v;
   endfunction

   task automatic model(input logic ua, input logic da, input logic ub, input logic db);
      int na, nb, w;
      if (m_st == 2) begin
         if (da || db) model_reset();
         else m_wage++;
      end else if (m_st == 1 || ua || ub) begin
         na = clampv(m_a + int'(ua) - int'(da));
         nb = clampv(m_b + int'(ub) - int'(db));
         w  = -1;
`ifdef SCORE_WIN_BY_TWO_EN
         if (na >= WIN && na - nb >= 2) w = 0;
         else if (nb >= WIN && nb - na >= 2) w = 1;
`else
         if (na == WIN) begin
            w = 0;
            if (nb > m_b) nb = m_b;
         end else if (nb == WIN) w = 1;
`endif
         m_a = na;
         m_b = nb;
         if (w >= 0) begin
            m_st = 2; m_win = w; m_wage = 0;
         end else begin
            m_st = 1; m_age++;
         end
      end else begin
         m_age++;
      end
   endtask

   function automatic logic [25:0] exp_vec();
      int sel, blank, win;
      sel   = (m_st == 2) ? m_win : (m_age / SHOW) % 2;
      blank = (m_st == 2) ? (m_wage / BLINK) % 2 : 0;
      win   = (m_st == 2) ? m_win : 0;
      return {2'(m_st), 7'(m_a), 7'(m_b), 7'(sel != 0 ? m_b : m_a), 1'(sel), 1'(blank), 1'(win)};
   endfunction

   function automatic logic [25:0] dut_vec();
      return {bus.state_o, bus.score_a_o, bus.score_b_o, bus.disp_val_o,
              bus.disp_sel_o, bus.disp_blank_o, bus.winner_o};
   endfunction

   // Inputs applied just after an edge, sampled by the next edge, outputs checked 1 time unit later.
   task automatic step(input logic ua, input logic da, input logic ub, input logic db);
      bus.up_a_i = ua; bus.down_a_i = da; bus.up_b_i = ub; bus.down_b_i = db;
      @(posedge clk);
      model(ua, da, ub, db);
      #1;
      check("outputs", 32'(dut_vec()), 32'(exp_vec()));
      bus.up_a_i = 1'b0; bus.down_a_i = 1'b0; bus.up_b_i = 1'b0; bus.down_b_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("reset_vec", 32'(dut_vec()), 32'd0);
   endtask

   typedef struct {
      logic ua, da, ub, db;
      int   st, a, b;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t1, t2, ntog, v1, v2;
      logic prev_sel;
      bus.up_a_i = 1'b0; bus.down_a_i = 1'b0; bus.up_b_i = 1'b0; bus.down_b_i = 1'b0;
      model_reset();

      // Expected state/scores worked out by hand from the rules.
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 2};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 2};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 3};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 2};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1};

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'(bus.state_o), 32'd0);
      check("reset_vec", 32'(dut_vec()), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].ua, tbl[i].da, tbl[i].ub, tbl[i].db);
         check($sformatf("vec%0d_state", i), 32'(bus.state_o), 32'(tbl[i].st));
         check($sformatf("vec%0d_a", i), 32'(bus.score_a_o), 32'(tbl[i].a));
         check($sformatf("vec%0d_b", i), 32'(bus.score_b_o), 32'(tbl[i].b));
      end

      // Asynchronous reset in the middle of a cycle with A=5, B=3.
      do_reset();
      repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("pre_rst_a", 32'(bus.score_a_o), 32'd5);
      check("pre_rst_b", 32'(bus.score_b_o), 32'd3);
      #3 rst = 1'b1;
      #1;
      check("async_rst_vec", 32'(dut_vec()), 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_vec", 32'(dut_vec()), 32'd0);
      rst = 1'b0;
      model_reset();

      // Display dwell: A=7, B=4 reached after 7 edges, then 2000 quiet cycles.
      repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("dwell_start_val", 32'(bus.disp_val_o), 32'd7);
      prev_sel = bus.disp_sel_o;
      t1 = -1; t2 = -1; ntog = 0; v1 = -1; v2 = -1;
      for (int i = 1; i <= 2000; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.disp_sel_o != prev_sel) begin
            ntog++;
            if (ntog == 1) begin t1 = i; v1 = int'(bus.disp_val_o); end
            if (ntog == 2) begin t2 = i; v2 = int'(bus.disp_val_o); end
            prev_sel = bus.disp_sel_o;
         end
      end
      check("dwell_toggles", 32'(ntog), 32'd2);
      check("dwell_first", 32'(t1), 32'(SHOW - 7));
      check("dwell_gap", 32'(t2 - t1), 32'(SHOW));
      check("dwell_val_b", 32'(v1), 32'd4);
      check("dwell_val_a", 32'(v2), 32'd7);

      // A=B=10 and both press up together.
      do_reset();
      repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SCORE_WIN_BY_TWO_EN
      check("deuce_state", 32'(bus.state_o), 32'd1);
      check("deuce_a", 32'(bus.score_a_o), 32'd11);
      check("deuce_b", 32'(bus.score_b_o), 32'd11);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("lead1_state", 32'(bus.state_o), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("by2_state", 32'(bus.state_o), 32'd2);
      check("by2_a", 32'(bus.score_a_o), 32'd13);
      check("by2_winner", 32'(bus.winner_o), 32'd0);
`else
      check("tie_state", 32'(bus.state_o), 32'd2);
      check("tie_winner", 32'(bus.winner_o), 32'd0);
      check("tie_a", 32'(bus.score_a_o), 32'd11);
      check("tie_b", 32'(bus.score_b_o), 32'd10);
      check("tie_sel", 32'(bus.disp_sel_o), 32'd0);
      check("tie_blank0", 32'(bus.disp_blank_o), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("win_up_ignored", 32'(bus.score_a_o), 32'd11);
      repeat (BLINK - 2) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("blink_before", 32'(bus.disp_blank_o), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("blink_on", 32'(bus.disp_blank_o), 32'd1);
      repeat (BLINK) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("blink_off", 32'(bus.disp_blank_o), 32'd0);
`endif
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("exit_state", 32'(bus.state_o), 32'd0);
      check("exit_a", 32'(bus.score_a_o), 32'd0);
      check("exit_b", 32'(bus.score_b_o), 32'd0);
      check("exit_sel", 32'(bus.disp_sel_o), 32'd0);

      // Random pulses checked cycle by cycle against the rule model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 6),
              1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
